// File: rtl/jt12_opram_pkg.sv
// Shared definitions for the jt12 operator-state RAM: sweep FSM encoding,
// legal read-latency range and the slot-address range helper.
package jt12_opram_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // DEPTH need not be a power of two, so a full-width address can name a missing slot.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/jt12_opram_if.sv
// Operator-RAM access bus: cycle enable, write port, read port and status.
// The pipeline stage drives it through the master modport; the RAM is the slave.
interface jt12_opram_if #(
    parameter int DW = 44,
    parameter int AW = 5
);
    logic          clk_en;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
    logic          busy;

    modport master (
        output clk_en, we, wr_addr, rd_addr, data,
        input  q, busy
    );

    modport slave (
        input  clk_en, we, wr_addr, rd_addr, data,
        output q, busy
    );
endinterface

// File: rtl/jt12_opram_core.sv
// Bare DW x DEPTH storage array: one write port, one registered read port,
// gated by clk_en. Kept free of reset and muxing so it maps onto block RAM.
module jt12_opram_core #(
    parameter int DW    = 44,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clk_en,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array and its read register are deliberately not reset; a reset
    // would block RAM inference. The top level clears slots with a sweep instead.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jt12_opram_gen.sv
// Parametrised operator-state RAM with post-reset clear sweep and 1- or 2-cycle
// read latency. Define JT12_OPRAM_BYPASS_EN for write-first same-slot reads.
module jt12_opram_gen
    import jt12_opram_pkg::*;
#(
    parameter int              DW      = 44,
    parameter int              DEPTH   = 32,
    parameter int              AW      = $clog2(DEPTH),
    parameter int              RD_LAT  = 1,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input logic         clk,
    input logic         rst_n,
    jt12_opram_if.slave bus
);

    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
    localparam bit            TWO_STAGE = (RD_LAT > RD_LAT_MIN);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("jt12_opram_gen: RD_LAT must be 1 or 2");
    end

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic          in_clear;
    logic          wr_ok;
    logic          rd_ok;

    assign in_clear = (state == ST_CLEAR);
    assign wr_ok    = addr_in_range(32'(bus.wr_addr), 32'(DEPTH));
    assign rd_ok    = addr_in_range(32'(bus.rd_addr), 32'(DEPTH));
    assign bus.busy = in_clear;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (bus.clk_en && in_clear) begin
            if (clr_cnt == LAST_SLOT) begin
                state <= ST_RUN;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

    // The sweep owns the write port; external writes are dropped until RUN.
    assign ram_we    = bus.clk_en && (in_clear || (bus.we && wr_ok));
    assign ram_waddr = in_clear ? clr_cnt : bus.wr_addr;
    assign ram_wdata = in_clear ? CLR_VAL : bus.data;

    jt12_opram_core #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk     (clk),
        .clk_en  (bus.clk_en),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (bus.rd_addr),
        .rd_data (ram_q)
    );

    logic byp_hit;

`ifdef JT12_OPRAM_BYPASS_EN
    assign byp_hit = !in_clear && bus.we && wr_ok && (bus.wr_addr == bus.rd_addr);
`else
    assign byp_hit = 1'b0;
`endif

    // Stage 1 is the core read register qualified by these flags: s1_vld marks
    // a real in-range RUN read, so CLEAR cycles and bad addresses read as 0.
    logic s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
        end else if (bus.clk_en) begin
            s1_vld <= !in_clear && rd_ok && !byp_hit;
        end
    end

`ifdef JT12_OPRAM_BYPASS_EN
    logic          s1_byp;
    logic [DW-1:0] s1_byp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_byp      <= 1'b0;
            s1_byp_data <= '0;
        end else if (bus.clk_en) begin
            s1_byp      <= byp_hit;
            s1_byp_data <= bus.data;
        end
    end
`endif

    logic [DW-1:0] s1_val;

    always_comb begin
        // NOTE: default first so no path leaves s1_val unassigned (no latch).
        s1_val = '0;
        if (s1_vld) begin
            s1_val = ram_q;
        end
`ifdef JT12_OPRAM_BYPASS_EN
        if (s1_byp) begin
            s1_val = s1_byp_data;
        end
`endif
    end

    if (TWO_STAGE) begin : g_lat2
        logic [DW-1:0] q_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_r <= '0;
            end else if (bus.clk_en) begin
                q_r <= in_clear ? '0 : s1_val;
            end
        end

        assign bus.q = q_r;
    end else begin : g_lat1
        assign bus.q = s1_val;
    end

endmodule

// File: tb/tb_jt12_opram_gen.sv
// Scoreboard bench for jt12_opram_gen: RD_LAT=1 and RD_LAT=2 instances share
// random stimulus and are checked against a slot-array reference model.
`timescale 1ns/1ps
module tb_jt12_opram_gen;

    localparam int DW    = 44;
    localparam int DEPTH = 24;
    localparam int AW    = $clog2(DEPTH);
`ifdef JT12_OPRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic          busy;
        logic [DW-1:0] q1;
        logic [DW-1:0] q2;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jt12_opram_if #(.DW(DW), .AW(AW)) bus1 ();
    jt12_opram_if #(.DW(DW), .AW(AW)) bus2 ();

    jt12_opram_gen #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    jt12_opram_gen #(.DW(DW), .DEPTH(DEPTH), .RD_LAT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic drive(input logic en, input logic w, input logic [AW-1:0] wa,
                         input logic [AW-1:0] ra, input logic [DW-1:0] d);
        bus1.clk_en = en; bus1.we = w; bus1.wr_addr = wa; bus1.rd_addr = ra; bus1.data = d;
        bus2.clk_en = en; bus2.we = w; bus2.wr_addr = wa; bus2.rd_addr = ra; bus2.data = d;
    endtask

    task automatic step(input logic en, input logic w, input logic [AW-1:0] wa,
                        input logic [AW-1:0] ra, input logic [DW-1:0] d);
        @(negedge clk);
        drive(en, w, wa, ra, d);
    endtask

    // Reference model: slot array plus clear-sweep progress, one update per active edge.
    logic [DW-1:0] mem [DEPTH];
    bit            m_busy = 1'b1;
    int            m_cnt  = 0;
    logic [DW-1:0] m_prev = '0;
    exp_t          exp_q[$];

    initial begin : model
        exp_t          e;
        logic [DW-1:0] r;
        int            ra, wa;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_prev = '0;
            end else if (bus1.clk_en) begin
                if (m_busy) begin
                    mem[m_cnt] = '0;
                    m_cnt++;
                    if (m_cnt == DEPTH) m_busy = 1'b0;
                    e = '{busy: m_busy, q1: '0, q2: '0};
                    m_prev = '0;
                end else begin
                    ra = int'(bus1.rd_addr);
                    wa = int'(bus1.wr_addr);
                    if (ra >= DEPTH) r = '0;
                    else if (BYP && bus1.we && wa == ra) r = bus1.data;
                    else r = mem[ra];
                    if (bus1.we && wa < DEPTH) mem[wa] = bus1.data;
                    e = '{busy: 1'b0, q1: r, q2: m_prev};
                    m_prev = r;
                end
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: every active edge presents a new output; idle edges must hold it.
    initial begin : monitor
        exp_t last;
        logic en, rs;
        last = '{busy: 1'b1, default: '0};
        forever begin
            @(posedge clk);
            en = bus1.clk_en;
            rs = rst_n;
            #1;
            if (!rs) begin
                last = '{busy: 1'b1, default: '0};
            end else if (en) begin
                check("sb_depth", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() != 0) last = exp_q.pop_front();
            end
            check("busy_lat1", 64'(bus1.busy), 64'(last.busy));
            check("q_lat1",    64'(bus1.q),    64'(last.q1));
            check("busy_lat2", 64'(bus2.busy), 64'(last.busy));
            check("q_lat2",    64'(bus2.q),    64'(last.q2));
        end
    end

    // Starts at a negedge with busy high; counts clk cycles until busy drops.
    task automatic sweep(input int period, input int want, input string name);
        int cyc;
        cyc = 0;
        while (bus1.busy && cyc < 1000) begin
            cyc++;
            drive((cyc % period) == 0, 1'b1, AW'($urandom % 32), AW'($urandom % 32), rnd_data());
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        check(name, 64'(cyc), 64'(want));
    endtask

    task automatic scan();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, AW'(i), rnd_data());
        repeat (2) step(1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_q1"},   64'(bus1.q),    64'd0);
        check({tag, "_q2"},   64'(bus2.q),    64'd0);
        check({tag, "_busy"}, 64'(bus1.busy & bus2.busy), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        drive(1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_q1",   64'(bus1.q),    64'd0);
        check("rst_q2",   64'(bus2.q),    64'd0);
        check("rst_busy", 64'(bus1.busy), 64'd1);

        rst_n = 1'b1;
        sweep(1, DEPTH, "sweep_len");
        scan();

        step(1'b1, 1'b1, AW'(5), '0, 44'h0AB_CDEF_0123);
        step(1'b1, 1'b0, '0, AW'(5), '0);
        repeat (3) step(1'b1, 1'b0, '0, '0, '0);

        step(1'b1, 1'b1, AW'(7), '0, 44'h1);
        step(1'b1, 1'b1, AW'(7), AW'(7), 44'h2);
        step(1'b1, 1'b0, '0, AW'(7), '0);
        repeat (3) step(1'b1, 1'b0, '0, '0, '0);

        step(1'b1, 1'b1, AW'(30), '0, rnd_data());
        step(1'b1, 1'b0, '0, AW'(30), '0);
        scan();

        @(negedge clk);
        async_reset_check("rst_idle");
        sweep(3, 3 * DEPTH, "sweep_len_en3");
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 32), AW'($urandom % 32), rnd_data());

        @(negedge clk);
        async_reset_check("rst_pre");
        repeat (10) step(1'b1, 1'b0, '0, '0, '0);
        #2;
        async_reset_check("rst_sweep10");
        sweep(1, DEPTH, "sweep_len_after_mid");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, AW'(i), '0, rnd_data() | 44'h1);
        step(1'b1, 1'b0, '0, AW'(3), '0);
        step(1'b1, 1'b0, '0, AW'(3), '0);
        @(posedge clk);
        #2;
        async_reset_check("rst_run");
        sweep(1, DEPTH, "sweep_len_after_run");
        scan();
        repeat (3) step(1'b0, 1'b0, '0, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
